divide_unit: RTL
================

# divide_unit

Sequential 32-bit integer divider for the multicycle MIPS datapath, sitting beside `Multiply` and feeding HI/LO into the register-bank write-data mux. `UC` starts it during `div`/`divu` execution and stalls on `EndDivFlag`. It implements restoring division at one quotient bit per clock over latched operands. It flags divide-by-zero so `UC` can take the exception path through `EPC`.

## Interface
- No parameters; width fixed at 32 bits.
- `Clk` input 1: single clock, all state updates on rising edge.
- `Reset` input 1: reset is synchronous and active-low (asserted when 0, sampled on rising `Clk`).
- `Start` input 1: request; sampled only in IDLE.
- `Signed` input 1: 1 = `div` (two's complement), 0 = `divu`; latched with `Start`.
- `A` input 32: dividend (from register A); latched with `Start`.
- `B` input 32: divisor (from register B); latched with `Start`.
- `Busy` output 1: high in every state except IDLE.
- `EndDivFlag` output 1: one-cycle completion pulse.
- `DivZero` output 1: high together with `EndDivFlag` when divisor was 0.
- `Hi` output 32: remainder, held until next successful completion.
- `Lo` output 32: quotient, held until next successful completion.

## Operation
- States: IDLE, PREP, ITER, FIX, DONE.
- IDLE: `Start`=1 → latch `A`, `B`, `Signed`; go PREP. `Start`=0 → stay.
- PREP: divisor==0 → set zero-flag, go DONE (`Hi`/`Lo` untouched). Otherwise record sign_q = Signed & (A[31]^B[31]) and sign_r = Signed & A[31]. Load magnitudes |A|, |B| (absolute value only if `Signed`). Clear 33-bit partial remainder and 6-bit counter; go ITER.
- ITER: shift {rem, quo} left 1 bit. Trial subtract rem − |B| in 33 bits. Non-negative → keep the difference and set quotient bit 0 = 1; otherwise restore and set the bit to 0. Counter increments; after the 32nd step go FIX.
- FIX: `Lo` ← sign_q ? −quo : quo. `Hi` ← sign_r ? −rem : rem. Go DONE.
- DONE: `EndDivFlag`=1, `DivZero`=zero-flag; go IDLE unconditionally, clearing zero-flag.
- Arithmetic: quotient truncates toward zero; remainder takes dividend's sign; |0x80000000| = 0x80000000 treated as unsigned magnitude. Signed 0x80000000 / 0xFFFFFFFF yields `Lo`=0x80000000, `Hi`=0 with no flag.
- `Start` while `Busy` is ignored and has no effect on the running operation. Operand changes after the latch edge are ignored.

## Timing
- Reset (`Reset`=0 at edge): state IDLE, `Busy`=0, `EndDivFlag`=0, `DivZero`=0, `Hi`=0, `Lo`=0, internal counter/remainder 0. Applies mid-operation, discarding the result.
- `Start` sampled at edge k: PREP after k, ITER after k+1, FIX after k+33, DONE after k+34.
- Normal completion: `EndDivFlag` high exactly during the cycle following edge k+34. `Hi`/`Lo` are valid in that same cycle and stable afterward.
- Divide-by-zero: DONE after edge k+1. `EndDivFlag`=`DivZero`=1 for that one cycle; `Hi`/`Lo` retain prior values.
- `Busy` is high from the cycle after edge k through the DONE cycle inclusive. A new `Start` is accepted at the edge ending DONE+1, i.e., in IDLE.
- All outputs are registered or a pure decode of state; no combinational path from `A`/`B`/`Start` to outputs.

## Test plan
- Unsigned: `Signed`=0, A=100, B=7, Start pulse at edge k → `EndDivFlag` high only in the cycle after k+34; `Lo`=14, `Hi`=2; `Busy` low next cycle.
- Signed negatives: A=0xFFFFFFF9 (−7), B=2 → `Lo`=0xFFFFFFFD, `Hi`=0xFFFFFFFF. A=7, B=0xFFFFFFFE → `Lo`=0xFFFFFFFD, `Hi`=1.
- Extremes: A=0x80000000, B=0xFFFFFFFF with `Signed`=1 → `Lo`=0x80000000, `Hi`=0. Same operands with `Signed`=0 → `Lo`=0, `Hi`=0x80000000.
- Divide by zero: preload `Hi`/`Lo` via 9/4 (Lo=2, Hi=1), then A=5, B=0 → `EndDivFlag`=`DivZero`=1 in the cycle after k+1; `Hi`=1, `Lo`=2 unchanged.
- Busy protection: start 100/7. At k+10, pulse `Start` with A=1, B=1 and change `A`/`B` → result still 14/2 at k+34, and only one `EndDivFlag` pulse.
- Reset mid-op: `Reset`=0 at edge k+20 → next cycle IDLE, `Busy`=0, `Hi`=`Lo`=0, and no `EndDivFlag` pulse for the aborted operation.

Source files
------------

// File: rtl/divide_unit.sv
module divide_unit (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic        Signed,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Busy,
  output logic        EndDivFlag,
  output logic        DivZero,
  output logic [31:0] Hi,
  output logic [31:0] Lo
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    ITER = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t      state;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic        signed_q;
  logic        sign_q;
  logic        sign_r;
  logic        zero_flag;
  logic [31:0] dvs;
  logic [31:0] rem;
  logic [31:0] quo;
  logic [5:0]  cnt;

  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [32:0] shifted;
  logic [32:0] diff;

  // The partial remainder is kept in 32 bits; the 33rd bit exists only in
  // the shifted trial value, which is sufficient because rem < |B| always.
  always_comb begin
    mag_a   = (signed_q && a_q[31]) ? -a_q : a_q;
    mag_b   = (signed_q && b_q[31]) ? -b_q : b_q;
    shifted = {rem, quo[31]};
    diff    = shifted - {1'b0, dvs};
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state     <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      signed_q  <= 1'b0;
      sign_q    <= 1'b0;
      sign_r    <= 1'b0;
      zero_flag <= 1'b0;
      dvs       <= '0;
      rem       <= '0;
      quo       <= '0;
      cnt       <= '0;
      Hi        <= '0;
      Lo        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (Start) begin
            a_q      <= A;
            b_q      <= B;
            signed_q <= Signed;
            state    <= PREP;
          end
        end
        PREP: begin
          if (b_q == '0) begin
            zero_flag <= 1'b1;
            state     <= DONE;
          end else begin
            sign_q <= signed_q & (a_q[31] ^ b_q[31]);
            sign_r <= signed_q & a_q[31];
            quo    <= mag_a;
            dvs    <= mag_b;
            rem    <= '0;
            cnt    <= '0;
            state  <= ITER;
          end
        end
        ITER: begin
          if (!diff[32]) begin
            rem <= diff[31:0];
            quo <= {quo[30:0], 1'b1};
          end else begin
            rem <= shifted[31:0];
            quo <= {quo[30:0], 1'b0};
          end
          cnt <= cnt + 6'd1;
          if (cnt == 6'd31) begin
            state <= FIX;
          end
        end
        FIX: begin
          Lo    <= sign_q ? -quo : quo;
          Hi    <= sign_r ? -rem : rem;
          state <= DONE;
        end
        DONE: begin
          zero_flag <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign Busy       = (state != IDLE);
  assign EndDivFlag = (state == DONE);
  assign DivZero    = (state == DONE) && zero_flag;

endmodule
